grf_wb_arbiter: RTL
===================

# grf_wb_arbiter

Write-port arbiter and scoreboard for the 32×32 general register file. It shares the GRF's single write port between the in-order pipeline writeback and a multi-cycle multiply/divide unit (MDU), using a small result queue for MDU writebacks. It tracks which registers have outstanding MDU writes so decode can stall on them, and it enforces a starvation bound on the MDU path. It sits between the W stage / MDU and the GRF write inputs (WE, A3, WD, PC).

## Interface
- QDEPTH, 2: MDU result queue depth (power of two, ≥2)
- STARVE_MAX, 4: cycles a queued MDU result may wait before pipeline hold is requested
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pipe_we  in  1  pipeline writeback request
- pipe_a3  in  5  pipeline destination register
- pipe_wd  in  32  pipeline write data
- pipe_pc  in  32  PC of the writing instruction (trace)
- mdu_valid  in  1  MDU result available
- mdu_ready  out  1  queue can accept; handshake completes on valid&&ready at clock edge
- mdu_a3 / mdu_wd / mdu_pc  in  5/32/32  MDU destination, data, PC
- issue_mdu  in  1  MDU op issued this cycle (marks destination pending)
- issue_a3  in  5  destination of issued MDU op
- rs_a / rt_a  in  5  decode source registers
- busy_rs / busy_rt  out  1  source has an outstanding MDU write
- pipe_hold  out  1  request to upstream: suppress pipe_we next cycle(s)
- grf_we / grf_a3 / grf_wd / grf_pc  out  1/5/32/32  GRF write port
- q_count  out  $clog2(QDEPTH)+1  queue occupancy
- hold_violation  out  1  sticky: pipe_we asserted while pipe_hold was high

## Operation
- Write to $0 is never a write: pipe_we with pipe_a3==0 does not use the port; MDU handshake with mdu_a3==0 is accepted and discarded (not enqueued, no scoreboard change); issue_mdu with issue_a3==0 is ignored.
- Port grant each cycle, combinational: if pipe_we && pipe_a3!=0, pipe wins (grf_* = pipe_*). Otherwise, if the queue is non-empty, the head is driven and popped at the edge. Otherwise grf_we=0.
- The pipeline is never back-pressured by the arbiter except via pipe_hold.
- Queue: FIFO with registered head/tail pointers wrapping modulo QDEPTH. mdu_ready = (q_count < QDEPTH), registered-state based. There is no pass-through when full: if the queue is full, ready=0 even in a pop cycle. Push and pop in the same cycle are allowed when not full; q_count is unchanged.
- Scoreboard: 32-bit pending mask; bit 0 is always 0.
  - issue_mdu sets bit issue_a3.
  - A pop to GRF clears bit grf_a3.
  - A set and clear of the same register in the same cycle: set wins.
  - busy_rs = pending[rs_a], busy_rt = pending[rt_a], combinational.
- Upstream guarantees no second issue to a register that is already pending, and no pipeline write to a pending register (decode stalls on busy).
- Starvation counter wait_cnt:
  - Increments each cycle the queue is non-empty and no pop occurs.
  - Clears on pop or when the queue is empty; saturates at STARVE_MAX.
  - pipe_hold = (wait_cnt == STARVE_MAX).
  - If pipe_we is nonetheless asserted with pipe_hold=1, the pipe still wins and hold_violation sets (cleared only by reset).

## Timing
- Reset (async assert): queue empty, pointers 0, pending mask 0, wait_cnt 0, hold_violation 0. While reset is high: grf_we=0, mdu_ready=0, busy_*=0, pipe_hold=0, q_count=0, and grf_a3/grf_wd/grf_pc=0.
- A reset mid-operation discards queued results; any MDU result in flight is lost, and upstream re-issues.
- MDU latency: handshake at edge N, earliest GRF write at edge N+1 (entry visible as head in cycle N+1).
- Worst-case MDU wait is STARVE_MAX+1 cycles if upstream honours pipe_hold within one cycle.
- Pipeline writes reach the GRF at the same edge they are presented (zero added latency).
- The busy bit sets visibly the cycle after issue_mdu. It clears visibly the cycle after the pop edge. The GRF write and clear happen at the same edge, so a read after the clear sees the new value.

## Test plan
- Reset, then MDU push {a3=5, wd=0x1234, pc=0x3000} with pipe idle: q_count=1 next cycle, then grf_we=1, a3=5, wd=0x1234 that cycle; busy for $5 (set by prior issue) drops after pop.
- Pipe writes $3 every cycle while one MDU result is queued: no pop; pipe_hold rises after 4 cycles. Pipe drops pipe_we, result pops next edge, and pipe_hold falls.
- Push 2 MDU results with continuous pipe writes: mdu_ready=0 at q_count=2. A third mdu_valid is held and not accepted; results pop in FIFO order with pointer wrap.
- MDU result with a3=0 and pipe_we with a3=0: grf_we stays 0, q_count unchanged, scoreboard unchanged.
- issue_mdu a3=7 on the same edge that a queued $7 entry pops: pending[7] remains 1.
- Assert reset asynchronously with q_count=2 and pending bits set: all outputs go to reset values immediately; after release, q_count=0 and busy_*=0.

Source files
------------

// File: rtl/grf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : grf_wb_arbiter
// Purpose  : Shares the GRF's single write port between the in-order pipeline
//            writeback and a multi-cycle MDU. MDU results wait in a small FIFO,
//            a pending-register scoreboard lets decode stall on outstanding
//            MDU writes, and a starvation counter asks upstream to hold the
//            pipeline when a queued MDU result has waited too long.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk, i_reset            clock / asynchronous active-high reset
//   i_pipe_we/a3/wd/pc        pipeline writeback request (wins the port)
//   i_mdu_valid, o_mdu_ready  MDU result handshake (valid && ready at edge)
//   i_mdu_a3/wd/pc            MDU result destination, data, trace PC
//   i_issue_mdu, i_issue_a3   MDU op issued; marks destination pending
//   i_rs_a, i_rt_a            decode source registers
//   o_busy_rs, o_busy_rt      source has an outstanding MDU write
//   o_pipe_hold               request upstream to suppress pipe writes
//   o_grf_we/a3/wd/pc         GRF write port
//   o_q_count                 MDU queue occupancy
//   o_hold_violation          sticky: pipe write seen while hold requested
// ============================================================================
module grf_wb_arbiter #(
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_pipe_we,
  input  logic [4:0]                i_pipe_a3,
  input  logic [31:0]               i_pipe_wd,
  input  logic [31:0]               i_pipe_pc,
  input  logic                      i_mdu_valid,
  output logic                      o_mdu_ready,
  input  logic [4:0]                i_mdu_a3,
  input  logic [31:0]               i_mdu_wd,
  input  logic [31:0]               i_mdu_pc,
  input  logic                      i_issue_mdu,
  input  logic [4:0]                i_issue_a3,
  input  logic [4:0]                i_rs_a,
  input  logic [4:0]                i_rt_a,
  output logic                      o_busy_rs,
  output logic                      o_busy_rt,
  output logic                      o_pipe_hold,
  output logic                      o_grf_we,
  output logic [4:0]                o_grf_a3,
  output logic [31:0]               o_grf_wd,
  output logic [31:0]               o_grf_pc,
  output logic [$clog2(QDEPTH):0]   o_q_count,
  output logic                      o_hold_violation
);

  localparam int c_PW = $clog2(QDEPTH);
  localparam int c_CW = c_PW + 1;
  localparam int c_WW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [c_CW-1:0] c_QDEPTH = c_CW'(QDEPTH);
  localparam logic [c_WW-1:0] c_STARVE = c_WW'(STARVE_MAX);

  // Queue storage is not reset: occupancy alone decides what is valid.
  logic [4:0]      r_q_a3 [QDEPTH];
  logic [31:0]     r_q_wd [QDEPTH];
  logic [31:0]     r_q_pc [QDEPTH];
  logic [c_PW-1:0] r_head;
  logic [c_PW-1:0] r_tail;
  logic [c_CW-1:0] r_count;
  logic [31:0]     r_pending;
  logic [c_WW-1:0] r_wait;
  logic            r_hold_viol;

  logic        w_pipe_win;
  logic        w_q_nempty;
  logic        w_pop;
  logic        w_ready;
  logic        w_push;
  logic        w_hold;
  logic [31:0] w_pend_nxt;

  assign w_pipe_win = i_pipe_we && (i_pipe_a3 != 5'd0);
  assign w_q_nempty = (r_count != '0);
  assign w_pop      = !w_pipe_win && w_q_nempty;
  // Ready looks only at registered occupancy: a full queue refuses even in
  // a pop cycle, so there is never a combinational path from pop to ready.
  assign w_ready    = !i_reset && (r_count < c_QDEPTH);
  // Results for $0 complete the handshake but are dropped on the floor.
  assign w_push     = i_mdu_valid && w_ready && (i_mdu_a3 != 5'd0);
  assign w_hold     = (r_wait == c_STARVE);

  assign o_mdu_ready      = w_ready;
  assign o_busy_rs        = !i_reset && r_pending[i_rs_a];
  assign o_busy_rt        = !i_reset && r_pending[i_rt_a];
  assign o_pipe_hold      = !i_reset && w_hold;
  assign o_q_count        = r_count;
  assign o_hold_violation = r_hold_viol;

  // Write-port grant: pipeline first, then queue head, else idle.
  always_comb begin
    o_grf_we = 1'b0;
    o_grf_a3 = 5'd0;
    o_grf_wd = 32'd0;
    o_grf_pc = 32'd0;
    if (!i_reset) begin
      if (w_pipe_win) begin
        o_grf_we = 1'b1;
        o_grf_a3 = i_pipe_a3;
        o_grf_wd = i_pipe_wd;
        o_grf_pc = i_pipe_pc;
      end else if (w_q_nempty) begin
        o_grf_we = 1'b1;
        o_grf_a3 = r_q_a3[r_head];
        o_grf_wd = r_q_wd[r_head];
        o_grf_pc = r_q_pc[r_head];
      end
    end
  end

  // Clear on pop first, then set on issue, so a same-register collision
  // leaves the bit pending for the newly issued op.
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_pop) begin
      w_pend_nxt[r_q_a3[r_head]] = 1'b0;
    end
    if (i_issue_mdu && (i_issue_a3 != 5'd0)) begin
      w_pend_nxt[i_issue_a3] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_a3[r_tail] <= i_mdu_a3;
      r_q_wd[r_tail] <= i_mdu_wd;
      r_q_pc[r_tail] <= i_mdu_pc;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_pending   <= 32'd0;
      r_wait      <= '0;
      r_hold_viol <= 1'b0;
    end else begin
      // Pointers wrap naturally because QDEPTH is a power of two.
      if (w_push) r_tail <= r_tail + c_PW'(1);
      if (w_pop)  r_head <= r_head + c_PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
      r_pending <= w_pend_nxt;
      if (!w_q_nempty || w_pop) begin
        r_wait <= '0;
      end else if (r_wait != c_STARVE) begin
        r_wait <= r_wait + c_WW'(1);
      end
      if (i_pipe_we && w_hold) begin
        r_hold_viol <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
